// File: rtl/uart_rx_engine.sv
// UART receiver: fractional baud ticks, 3-sample majority vote, frame FSM and a
// status-tagged receive FIFO with overflow/idle-timeout flags and valid/ready output.
module uart_rx_engine #(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_WIDTH     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_in,
  input  logic [DIV_WIDTH-1:0]           baud_div,
  input  logic [3:0]                     baud_frac,
  input  logic [3:0]                     data_bits,
  input  logic [1:0]                     parity_mode,
  input  logic                           stop_bits,
  input  logic                           lsb_first,
  input  logic [7:0]                     timeout_bits,
  output logic [MAX_DATA_BITS-1:0]       m_data,
  output logic [2:0]                     m_status,
  output logic                           m_valid,
  input  logic                           m_ready,
  input  logic                           fifo_clear,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           overflow,
  output logic                           timeout,
  input  logic                           err_clear,
  output logic                           busy
);
  localparam int W  = MAX_DATA_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2} state_t;

  // ---------------- tick generator ----------------
  logic [DIV_WIDTH:0] bcnt_q, div_eff, period_m1;
  logic [3:0]         acc_q;
  logic               stretch_q, tick_q;

  assign div_eff   = (baud_div < DIV_WIDTH'(2)) ? (DIV_WIDTH+1)'(2) : {1'b0, baud_div};
  assign period_m1 = div_eff + {{DIV_WIDTH{1'b0}}, stretch_q} - (DIV_WIDTH+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q    <= '0;
      acc_q     <= '0;
      stretch_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bcnt_q >= period_m1) begin
        bcnt_q <= '0;
        tick_q <= 1'b1;
        // Carry out of the fractional accumulator lengthens the next tick by one clock.
        {stretch_q, acc_q} <= {1'b0, acc_q} + {1'b0, baud_frac};
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  // ---------------- frame FSM ----------------
  state_t         st_q;
  logic [PW-1:0]  ph_q;
  logic [1:0]     smp_q;
  logic [W-1:0]   sh_q, dout;
  logic [3:0]     bitn_q, nb_q, nb_in;
  logic [1:0]     pm_q;
  logic           sb_q, lsb_q, par_q, pbit_q, perr_q, ferr_q, brk_q;
  logic           armed_q, rxp_q, push_q, busy_q;
  logic [W+2:0]   ent_q;
  logic           vote, exp_par, fin_brk, fin_ferr;

  assign nb_in    = (data_bits < 4'd5 || data_bits > 4'(W)) ? 4'(W) : data_bits;
  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_in) | (smp_q[1] & rx_in);
  assign exp_par  = (pm_q == 2'd1) ? ~par_q : (pm_q == 2'd2) ? par_q : 1'b1;
  assign dout     = lsb_q ? (sh_q >> (4'(W) - nb_q)) : sh_q;
  assign fin_ferr = ferr_q | ~vote;
  assign fin_brk  = (st_q == S_STOP1) ? (~vote & (sh_q == '0) & ((pm_q == 2'd0) | ~pbit_q))
                                      : brk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= S_IDLE;  ph_q <= '0;    smp_q <= '0;   sh_q <= '0;
      bitn_q <= '0;    nb_q <= '0;    pm_q <= '0;    sb_q <= 1'b0;
      lsb_q <= 1'b0;   par_q <= 1'b0; pbit_q <= 1'b0; perr_q <= 1'b0;
      ferr_q <= 1'b0;  brk_q <= 1'b0; armed_q <= 1'b0; rxp_q <= 1'b0;
      push_q <= 1'b0;  busy_q <= 1'b0; ent_q <= '0;
    end else begin
      push_q <= 1'b0;
      rxp_q  <= rx_in;
      if (st_q == S_IDLE) begin
        if (!armed_q) begin
          armed_q <= rx_in;
        end else if (rxp_q && !rx_in) begin
          st_q   <= S_START;
          busy_q <= 1'b1;
          ph_q   <= '0;
          nb_q   <= nb_in;
          pm_q   <= parity_mode;
          sb_q   <= stop_bits;
          lsb_q  <= lsb_first;
          sh_q   <= '0;
          bitn_q <= '0;
          par_q  <= 1'b0;
          pbit_q <= 1'b0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
          brk_q  <= 1'b0;
        end
      end else if (tick_q) begin
        ph_q <= ph_q + 1'b1;
        if (ph_q == PW'(OVERSAMPLE/2-1)) smp_q[0] <= rx_in;
        if (ph_q == PW'(OVERSAMPLE/2))   smp_q[1] <= rx_in;
        if (ph_q == PW'(OVERSAMPLE/2+1)) begin
          case (st_q)
            S_START: begin
              if (vote) begin
                st_q   <= S_IDLE;
                busy_q <= 1'b0;
              end else begin
                st_q <= S_DATA;
              end
            end
            S_DATA: begin
              sh_q   <= lsb_q ? {vote, sh_q[W-1:1]} : {sh_q[W-2:0], vote};
              par_q  <= par_q ^ vote;
              bitn_q <= bitn_q + 4'd1;
              if (bitn_q == nb_q - 4'd1) st_q <= (pm_q != 2'd0) ? S_PAR : S_STOP1;
            end
            S_PAR: begin
              pbit_q <= vote;
              perr_q <= vote ^ exp_par;
              st_q   <= S_STOP1;
            end
            default: begin
              ferr_q <= fin_ferr;
              brk_q  <= fin_brk;
              if (st_q == S_STOP1 && sb_q) begin
                st_q <= S_STOP2;
              end else begin
                // Leave at mid stop bit so the next start edge is caught immediately.
                st_q    <= S_IDLE;
                busy_q  <= 1'b0;
                push_q  <= 1'b1;
                ent_q   <= {fin_brk, perr_q, fin_ferr, dout};
                armed_q <= ~fin_brk;
              end
            end
          endcase
        end
      end
    end
  end

  assign busy = busy_q;

  // ---------------- receive FIFO ----------------
  logic [W+2:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          full, do_pop, do_push, ovf_evt;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign m_valid = (cnt_q != '0);
  assign do_pop  = m_valid & m_ready & ~fifo_clear;
  assign do_push = push_q & (~full | do_pop) & ~fifo_clear;
  assign ovf_evt = push_q & full & ~do_pop & ~fifo_clear;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= ent_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (fifo_clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign fifo_count = cnt_q;
  assign m_data     = m_valid ? mem_q[rptr_q][W-1:0] : '0;
  assign m_status   = m_valid ? mem_q[rptr_q][W+2:W] : 3'b000;

  // ---------------- idle timeout and sticky flags ----------------
  logic [PW-1:0] idle_ph_q;
  logic [7:0]    idle_bits_q;
  logic          to_evt, ovf_q, to_q;

  assign to_evt = (timeout_bits != 8'd0) && (idle_bits_q == timeout_bits) && m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_ph_q   <= '0;
      idle_bits_q <= '0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      if (st_q != S_IDLE || do_push || do_pop) begin
        idle_ph_q   <= '0;
        idle_bits_q <= '0;
      end else if (tick_q && rx_in) begin
        idle_ph_q <= idle_ph_q + 1'b1;
        if (idle_ph_q == PW'(OVERSAMPLE-1) && idle_bits_q != 8'hFF)
          idle_bits_q <= idle_bits_q + 8'd1;
      end
      if (ovf_evt)        ovf_q <= 1'b1;
      else if (err_clear) ovf_q <= 1'b0;
      if (to_evt)         to_q  <= 1'b1;
      else if (err_clear) to_q  <= 1'b0;
    end
  end

  assign overflow = ovf_q;
  assign timeout  = to_q;
endmodule
